// File: rtl/booth_datapath_if.sv
// booth_datapath_if: control-unit strobes, operands and product handshake for the Booth datapath.
// seq_error is present only when BOOTH_SHIFT_CHECK_EN is defined.
interface booth_datapath_if #(parameter int WIDTH = 7);
   logic signed [WIDTH-1:0] multiplicand;
   logic signed [WIDTH-1:0] multiplier;
   logic CargaQ, CargaA, CargaM, CargaQm1;
   logic suma, resta, desplazaA, desplazaQ, resetA, fin;
   logic q0, qm1;
   logic [2*WIDTH-1:0] product;
   logic product_valid, product_ack;
`ifdef BOOTH_SHIFT_CHECK_EN
   logic seq_error;
`endif
   modport master (
      output multiplicand, multiplier, CargaQ, CargaA, CargaM, CargaQm1,
      output suma, resta, desplazaA, desplazaQ, resetA, fin, product_ack,
      input q0, qm1, product, product_valid
`ifdef BOOTH_SHIFT_CHECK_EN
      , seq_error
`endif
   );
   modport slave (
      input multiplicand, multiplier, CargaQ, CargaA, CargaM, CargaQm1,
      input suma, resta, desplazaA, desplazaQ, resetA, fin, product_ack,
      output q0, qm1, product, product_valid
`ifdef BOOTH_SHIFT_CHECK_EN
      , seq_error
`endif
   );
endinterface

// File: rtl/booth_datapath.sv
// booth_datapath: A/Q/M/Qm1 registers, add/sub and product capture with valid/ack handshake.
// Optional BOOTH_SHIFT_CHECK_EN adds a shift counter and sticky seq_error.
module booth_datapath #(parameter int WIDTH = 7) (
   input logic clk,
   input logic reset_n,
   booth_datapath_if.slave bus
);
   logic [WIDTH:0] a, m, a_arith, a_next;
   logic [WIDTH-1:0] q;
   logic [2*WIDTH-1:0] product_r;
   logic qm1_r, done_seen, captured, valid_r;
   logic active, shift, capture, op_add, op_sub;
   // CargaQ restarts the datapath even after termination froze it
   assign active = !done_seen || bus.CargaQ;
   assign shift = bus.desplazaA || bus.desplazaQ;
   assign capture = done_seen && !captured && !bus.CargaQ;
   always_comb begin
      op_add = bus.suma && (!bus.resta || {q[0], qm1_r} == 2'b01);
      op_sub = bus.resta && (!bus.suma || {q[0], qm1_r} == 2'b10);
      a_arith = op_add ? a + m : op_sub ? a - m : a;
      a_next = bus.resetA ? '0 : shift ? {a[WIDTH], a[WIDTH:1]} : bus.CargaA ? a_arith : a;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a <= '0;
         q <= '0;
         m <= '0;
         qm1_r <= 1'b0;
         done_seen <= 1'b0;
         captured <= 1'b0;
         product_r <= '0;
         valid_r <= 1'b0;
      end else begin
         if (active) begin
            a <= a_next;
            q <= bus.CargaQ ? bus.multiplier : shift ? {a[0], q[WIDTH-1:1]} : q;
            qm1_r <= shift ? q[0] : bus.CargaQm1 ? 1'b0 : qm1_r;
            if (bus.CargaM) m <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
         end
         done_seen <= bus.CargaQ ? 1'b0 : done_seen || bus.fin;
         captured <= bus.CargaQ ? 1'b0 : captured || capture;
         if (capture) product_r <= {a[WIDTH-1:0], q};
         valid_r <= bus.CargaQ ? 1'b0 : capture ? 1'b1 : valid_r && !bus.product_ack;
      end
   end
   assign bus.q0 = q[0];
   assign bus.qm1 = qm1_r;
   assign bus.product = product_r;
   assign bus.product_valid = valid_r;
`ifdef BOOTH_SHIFT_CHECK_EN
   logic [3:0] cnt;
   logic seq_err_r;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
         seq_err_r <= 1'b0;
      end else begin
         cnt <= bus.CargaQ ? 4'd0 : (active && shift && cnt != 4'd15) ? cnt + 4'd1 : cnt;
         seq_err_r <= bus.CargaQ ? 1'b0 : capture ? (cnt != 4'(WIDTH)) : seq_err_r;
      end
   end
   assign bus.seq_error = seq_err_r;
`endif
endmodule
